// File: rtl/crc_frame_tx.sv
// crc_frame_tx: captures {data, crc} pairs on the rising edge of crc_done,
// buffers them in a small FIFO and serialises each frame MSB-first over a
// valid/ready interface with start/end-of-frame markers.
module crc_frame_tx #(
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned CRC_W      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [DATA_W-1:0]               i_data,
  input  logic [CRC_W-1:0]                i_crc_code,
  input  logic                            i_crc_done,
  input  logic                            i_tx_ready,
  output logic                            o_tx_bit,
  output logic                            o_tx_valid,
  output logic                            o_tx_sof,
  output logic                            o_tx_eof,
  output logic                            o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count
);

  localparam int unsigned FrameW = DATA_W + CRC_W;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned BitW   = $clog2(FrameW);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic                done_q, done_d;
  logic [FrameW-1:0]   mem_q [FIFO_DEPTH];
  logic [FrameW-1:0]   mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [FrameW-1:0]   shreg_q, shreg_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                overflow_q, overflow_d;

  logic push_req;
  logic push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;
  logic last_bit;
  logic xfer;

  assign push_req   = i_crc_done & ~done_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign last_bit   = (bit_cnt_q == BitW'(FrameW - 1));
  assign xfer       = (state_q == StShift) & i_tx_ready;

  // Pop from the FIFO when idle with work waiting, or to reload the shifter
  // on the last accepted bit so back-to-back frames leave no gap.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == StIdle) begin
        pop = 1'b1;
      end else if (xfer && last_bit) begin
        pop = 1'b1;
      end
    end
  end

  // A full FIFO still accepts a push when a pop frees the slot this cycle.
  always_comb begin
    push       = push_req & (~fifo_full | pop);
    overflow_d = push_req & fifo_full & ~pop;
    done_d     = i_crc_done;
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {i_data, i_crc_code};
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Shift register and bit counter; both hold while the sink stalls.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (pop) begin
      shreg_d   = mem_q[rd_ptr_q];
      bit_cnt_d = '0;
    end else if (xfer && !last_bit) begin
      shreg_d   = {shreg_q[FrameW-2:0], 1'b0};
      bit_cnt_d = bit_cnt_q + BitW'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StShift;
      end
      StShift: begin
        if (xfer && last_bit && fifo_empty) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame storage needs no reset; occupancy tracking guards every read.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  // Outputs decode registered state only, so i_tx_ready never reaches them.
  always_comb begin
    o_tx_valid   = (state_q == StShift);
    o_tx_bit     = o_tx_valid & shreg_q[FrameW-1];
    o_tx_sof     = o_tx_valid & (bit_cnt_q == '0);
    o_tx_eof     = o_tx_valid & last_bit;
    o_overflow   = overflow_q;
    o_fifo_count = count_q;
  end

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed testbench for crc_frame_tx with hand-computed serial frames.
module tb_crc_frame_tx;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [2:0] i_data;
  logic [3:0] i_crc_code;
  logic       i_crc_done;
  logic       i_tx_ready;
  logic       o_tx_bit;
  logic       o_tx_valid;
  logic       o_tx_sof;
  logic       o_tx_eof;
  logic       o_overflow;
  logic [1:0] o_fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-built frames {data, crc}, MSB first on the wire.
  localparam logic [6:0] FrmA = 7'b101_0011;
  localparam logic [6:0] FrmB = 7'b010_1100;
  localparam logic [6:0] FrmC = 7'b111_0001;
  localparam logic [6:0] FrmD = 7'b000_1010;

  crc_frame_tx #(
    .DATA_W    (3),
    .CRC_W     (4),
    .FIFO_DEPTH(2)
  ) u_dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_crc_code  (i_crc_code),
    .i_crc_done  (i_crc_done),
    .i_tx_ready  (i_tx_ready),
    .o_tx_bit    (o_tx_bit),
    .o_tx_valid  (o_tx_valid),
    .o_tx_sof    (o_tx_sof),
    .o_tx_eof    (o_tx_eof),
    .o_overflow  (o_overflow),
    .o_fifo_count(o_fifo_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present a frame and raise done for exactly one cycle.
  task automatic done_pulse(input logic [6:0] f);
    i_data     = f[6:4];
    i_crc_code = f[3:0];
    i_crc_done = 1'b1;
    tick();
    i_crc_done = 1'b0;
  endtask

  // Consume one frame starting at the current cycle; checks every cycle,
  // including stalled ones, so frozen bits/markers are verified too.
  task automatic expect_frame(input logic [6:0] f, input bit toggle, input string tag);
    int idx = 0;
    int cyc = 0;
    logic [6:0] fv = f;
    while (idx < 7 && cyc < 60) begin
      if (toggle) i_tx_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else        i_tx_ready = 1'b1;
      check_eq($sformatf("%s valid b%0d", tag, idx), 32'(o_tx_valid), 32'd1);
      check_eq($sformatf("%s bit b%0d", tag, idx), 32'(o_tx_bit), 32'(fv[6-idx]));
      check_eq($sformatf("%s sof b%0d", tag, idx), 32'(o_tx_sof), 32'(idx == 0));
      check_eq($sformatf("%s eof b%0d", tag, idx), 32'(o_tx_eof), 32'(idx == 6));
      if (i_tx_ready) idx++;
      cyc++;
      tick();
    end
    if (idx < 7) check_eq({tag, " timeout"}, 32'(idx), 32'd7);
  endtask

  initial begin
    int max_cnt;
    i_rst      = 1'b1;
    i_data     = '0;
    i_crc_code = '0;
    i_crc_done = 1'b0;
    i_tx_ready = 1'b0;
    tick();
    tick();
    check_eq("rst valid", 32'(o_tx_valid), 32'd0);
    check_eq("rst sof", 32'(o_tx_sof), 32'd0);
    check_eq("rst eof", 32'(o_tx_eof), 32'd0);
    check_eq("rst bit", 32'(o_tx_bit), 32'd0);
    check_eq("rst ovf", 32'(o_overflow), 32'd0);
    check_eq("rst count", 32'(o_fifo_count), 32'd0);
    i_rst = 1'b0;

    // 1: single frame, ready held high, latency check.
    i_tx_ready = 1'b1;
    done_pulse(FrmA);
    check_eq("t1 count after push", 32'(o_fifo_count), 32'd1);
    check_eq("t1 valid after push", 32'(o_tx_valid), 32'd0);
    tick();
    check_eq("t1 count after pop", 32'(o_fifo_count), 32'd0);
    expect_frame(FrmA, 1'b0, "t1");
    check_eq("t1 valid end", 32'(o_tx_valid), 32'd0);

    // 2: same frame with a stalling sink.
    i_tx_ready = 1'b0;
    done_pulse(FrmA);
    tick();
    expect_frame(FrmA, 1'b1, "t2");
    check_eq("t2 valid end", 32'(o_tx_valid), 32'd0);

    // 3: two frames back to back, no idle gap.
    i_tx_ready = 1'b0;
    done_pulse(FrmA);
    tick();
    done_pulse(FrmB);
    check_eq("t3 count", 32'(o_fifo_count), 32'd1);
    expect_frame(FrmA, 1'b0, "t3a");
    expect_frame(FrmB, 1'b0, "t3b");
    check_eq("t3 valid end", 32'(o_tx_valid), 32'd0);

    // 4: four edges with the sink stalled; the fourth overflows.
    i_tx_ready = 1'b0;
    done_pulse(FrmA);
    tick();
    check_eq("t4 count e1", 32'(o_fifo_count), 32'd0);
    check_eq("t4 valid e1", 32'(o_tx_valid), 32'd1);
    done_pulse(FrmB);
    check_eq("t4 count e2", 32'(o_fifo_count), 32'd1);
    tick();
    done_pulse(FrmC);
    check_eq("t4 count e3", 32'(o_fifo_count), 32'd2);
    check_eq("t4 ovf e3", 32'(o_overflow), 32'd0);
    tick();
    done_pulse(FrmD);
    check_eq("t4 ovf e4", 32'(o_overflow), 32'd1);
    check_eq("t4 count e4", 32'(o_fifo_count), 32'd2);
    tick();
    check_eq("t4 ovf pulse end", 32'(o_overflow), 32'd0);
    expect_frame(FrmA, 1'b0, "t4a");
    expect_frame(FrmB, 1'b0, "t4b");
    expect_frame(FrmC, 1'b0, "t4c");
    check_eq("t4 valid end", 32'(o_tx_valid), 32'd0);
    check_eq("t4 count end", 32'(o_fifo_count), 32'd0);

    // 5: done held high for 10 cycles gives one frame only.
    i_tx_ready = 1'b0;
    i_data     = FrmB[6:4];
    i_crc_code = FrmB[3:0];
    i_crc_done = 1'b1;
    max_cnt    = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int'(o_fifo_count) > max_cnt) max_cnt = int'(o_fifo_count);
    end
    i_crc_done = 1'b0;
    check_eq("t5 max count", 32'(max_cnt), 32'd1);
    check_eq("t5 count", 32'(o_fifo_count), 32'd0);
    expect_frame(FrmB, 1'b0, "t5");
    check_eq("t5 valid end", 32'(o_tx_valid), 32'd0);
    check_eq("t5 count end", 32'(o_fifo_count), 32'd0);

    // 6: reset at bit 4 with one frame buffered.
    i_tx_ready = 1'b0;
    done_pulse(FrmA);
    tick();
    done_pulse(FrmB);
    check_eq("t6 count pre", 32'(o_fifo_count), 32'd1);
    i_tx_ready = 1'b1;
    tick();
    tick();
    tick();
    check_eq("t6 bit4", 32'(o_tx_bit), 32'(FrmA[3]));
    check_eq("t6 sof bit4", 32'(o_tx_sof), 32'd0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check_eq("t6 valid rst", 32'(o_tx_valid), 32'd0);
    check_eq("t6 count rst", 32'(o_fifo_count), 32'd0);
    check_eq("t6 ovf rst", 32'(o_overflow), 32'd0);
    done_pulse(FrmC);
    tick();
    expect_frame(FrmC, 1'b0, "t6");
    check_eq("t6 valid end", 32'(o_tx_valid), 32'd0);
    check_eq("t6 count end", 32'(o_fifo_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
